bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. Sits directly upstream of the BCD-to-7-segment decoders. Each 4-bit digit of `bcd_o` drives one decoder instance. Conversion is started by a one-cycle handshake and its completion is flagged by a one-cycle `done` pulse; the result stays held between conversions so the displays remain stable.

---
 rtl/bin_to_bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock. Start with a one-cycle handshake; a one-cycle
// done pulse marks the edge on which bcd_o is refreshed. bcd_o holds its
// value between conversions so the downstream 7-segment decoders stay stable.
//
// Optional build macro: BLANK_LEADING_ZEROS_EN
//   defined   - zero digits above the most significant nonzero digit are
//               replaced by 4'hF (decoder shows blank); digit 0 never blanks.
//   undefined - raw BCD digits, leading zeros shown.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  done,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

`ifdef BLANK_LEADING_ZEROS_EN
    // Blank display with a single 0 in the units position.
    localparam logic [BCD_W-1:0] RESET_PATTERN = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] RESET_PATTERN = '0;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sr;
    logic [BCD_W-1:0] r_bcd;
    logic             r_done;
    logic             r_busy;

    logic [SR_W-1:0]  w_corr;
    logic [BCD_W-1:0] w_field;
    logic [BCD_W-1:0] w_bcd_out;

    assign w_field = r_sr[SR_W-1 -: BCD_W];

    // Add-3 correction applied to every BCD digit >= 5, all in parallel.
    always_comb begin
        // NOTE: full default assignment first, so no path leaves w_corr unassigned (no latch).
        w_corr = r_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_sr[WIDTH + 4*k +: 4] >= 4'd5) begin
                w_corr[WIDTH + 4*k +: 4] = r_sr[WIDTH + 4*k +: 4] + 4'd3;
            end
        end
    end

    // Final display value: optional leading-zero blanking from the top digit down.
    always_comb begin
`ifdef BLANK_LEADING_ZEROS_EN
        logic seen;
        seen      = 1'b0;
        w_bcd_out = w_field;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_field[4*k +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                w_bcd_out[4*k +: 4] = 4'hF;
            end
        end
`else
        w_bcd_out = w_field;
`endif
    end

    // Control FSM, shift register, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_bcd   <= RESET_PATTERN;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= {{BCD_W{1'b0}}, bin_in};
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_corr << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // busy stays high through the IDLE cycle that follows, so
                    // it drops one edge after done unless a new start arrives.
                    r_bcd   <= w_bcd_out;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd_o = r_bcd;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq (WIDTH=16, DIGITS=5). Expected digits come
// from a decimal model using plain division; honours BLANK_LEADING_ZEROS_EN.
module tb_bin_to_bcd_seq;

    localparam int WIDTH   = 16;
    localparam int DIGITS  = 5;
    localparam int LAT     = WIDTH + 1;
    localparam int PERIOD  = WIDTH + 2;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin_in;
    logic [4*DIGITS-1:0] bcd_o;
    logic                done;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hist [0:8191];

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .bcd_o  (bcd_o),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [19:0] RESET_EXP = 20'hFFFF0;
`else
    localparam logic [19:0] RESET_EXP = 20'h00000;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decimal reference: digit k = (v / 10^k) % 10, blanked if v < 10^k (k > 0).
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] res;
        int p;
        int d;
        res = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = (v / p) % 10;
`ifdef BLANK_LEADING_ZEROS_EN
            if (k > 0 && v < p) d = 15;
`endif
            res[4*k +: 4] = d[3:0];
            p = p * 10;
        end
        return res;
    endfunction

    // Wait (bounded) for done; returns cycle of the done edge or -1.
    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        while (!done && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        dcyc = done ? cyc : -1;
    endtask

    task automatic run_conv(input int v, input string tag);
        int n0;
        int d;
        @(negedge clk);
        bin_in = v[WIDTH-1:0];
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n0 = cyc;
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        wait_done(d);
        check({tag, "_latency"}, d - n0, LAT);
        check({tag, "_bcd"}, 32'(bcd_o), 32'(ref_bcd(v)));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_bcd_hold"}, 32'(bcd_o), 32'(ref_bcd(v)));
    endtask

    initial begin
        int n0;
        int d;
        int d0;
        int prev;
        int got;

        rst = 1'b1; start = 1'b0; bin_in = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd", 32'(bcd_o), 32'(RESET_EXP));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_conv(0, "zero");
        run_conv(65535, "max");
        run_conv(1234, "v1234");
        run_conv(42, "v42");

        // Start while busy is ignored and not queued.
        @(negedge clk);
        bin_in = 16'd1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n0 = cyc; d0 = done_cnt;
        repeat (4) @(negedge clk);
        bin_in = 16'd999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d);
        check("ign_latency", d - n0, LAT);
        check("ign_bcd", 32'(bcd_o), 32'(ref_bcd(1234)));
        repeat (2 * PERIOD) @(negedge clk);
        check("ign_done_count", done_cnt - d0, 1);
        run_conv(999, "v999");

        // Reset mid-conversion aborts it.
        @(negedge clk);
        bin_in = 16'd500; start = 1'b1;
        @(negedge clk);
        start = 1'b0; d0 = done_cnt;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_o), 32'(RESET_EXP));
        rst = 1'b0;
        repeat (PERIOD + 4) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_conv(7, "v7");

        // Back-to-back random sweep; bin_in changes every cycle.
        got = 0; prev = -1;
        @(negedge clk);
        start = 1'b1;
        bin_in = WIDTH'($urandom_range(0, 65535));
        hist[cyc + 1] = int'(bin_in);
        for (int i = 0; i < 25 * PERIOD && got < 20; i++) begin
            @(negedge clk);
            if (done) begin
                check("rand_bcd", 32'(bcd_o), 32'(ref_bcd(hist[cyc - LAT])));
                if (prev >= 0) check("rand_spacing", cyc - prev, PERIOD);
                prev = cyc;
                got++;
            end
            bin_in = WIDTH'($urandom_range(0, 65535));
            hist[cyc + 1] = int'(bin_in);
        end
        check("rand_count", got, 20);
        start = 1'b0;
        repeat (PERIOD + 2) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
